// File: rtl/mult_ex.sv
// mult_ex: iterative multi-cycle multiply unit for the EX stage.
//
// Takes the multiplicand, the selected (optionally inverted) multiplier and
// the writeback tags from the RF->EX register, computes the low WIDTH bits of
// the product one step per cycle, and strobes the result to writeback.
//
// Build option: define MULT_RADIX4_EN to retire two multiplier bits per step
// (WIDTH/2 steps) instead of one (WIDTH steps).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               cancels any in-flight or arriving operation
//   mult_en, mult_inst_vld
//                       accept qualifiers from the RF->EX register
//   mult_op1            multiplicand
//   mult_op2, mult_imm  register / immediate multiplier
//   mult_imm_vld        selects mult_imm over mult_op2
//   mult_invtRt         bitwise-inverts the selected multiplier
//   mult_done_idx, phy_addr_mult, reg_wrt_mul
//                       writeback tags captured at accept
//   stall               unit busy, holds the RF->EX register
//   mult_result, mult_result_vld
//                       low WIDTH bits of the product, one-cycle strobe
//   mult_done_idx_out, phy_addr_mult_out, reg_wrt_mul_out
//                       tags that go with mult_result
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | free; accepts a new operation
// CALC  | one multiplier step per cycle
// DONE  | result and tags presented, strobe high for this cycle

module mult_ex #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             mult_en,
  input  logic             mult_inst_vld,
  input  logic [WIDTH-1:0] mult_op1,
  input  logic [WIDTH-1:0] mult_op2,
  input  logic [WIDTH-1:0] mult_imm,
  input  logic             mult_imm_vld,
  input  logic             mult_invtRt,
  input  logic [5:0]       mult_done_idx,
  input  logic [5:0]       phy_addr_mult,
  input  logic             reg_wrt_mul,
  output logic             stall,
  output logic [WIDTH-1:0] mult_result,
  output logic             mult_result_vld,
  output logic [5:0]       mult_done_idx_out,
  output logic [5:0]       phy_addr_mult_out,
  output logic             reg_wrt_mul_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef MULT_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
`else
  localparam int STEPS = WIDTH;
`endif
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] mplr_eff;
  logic [5:0]       idx_q;
  logic [5:0]       phy_q;
  logic             wrt_q;
  logic             accept;
  logic             last_step;
`ifdef MULT_RADIX4_EN
  logic [WIDTH-1:0] mcand3;
`endif

  assign accept    = (state == IDLE) && mult_en && mult_inst_vld && !flush;
  assign last_step = (state == CALC) && (cnt == LAST_CNT);
  assign mplr_eff  = (mult_imm_vld ? mult_imm : mult_op2) ^ {WIDTH{mult_invtRt}};

  // A flush arriving in the DONE cycle still suppresses the strobe.
  assign mult_result_vld = (state == DONE) && !flush;

  always_comb begin
    addend = '0;
`ifdef MULT_RADIX4_EN
    case (mplr[1:0])
      2'b01:   addend = mcand;
      2'b10:   addend = mcand << 1;
      2'b11:   addend = mcand3;
      default: addend = '0;
    endcase
`else
    if (mplr[0]) addend = mcand;
`endif
    acc_nxt = acc + addend;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = CALC;
        CALC:    if (last_step) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      stall             <= 1'b0;
      cnt               <= '0;
      mcand             <= '0;
      mplr              <= '0;
      acc               <= '0;
      idx_q             <= '0;
      phy_q             <= '0;
      wrt_q             <= 1'b0;
      mult_result       <= '0;
      mult_done_idx_out <= '0;
      phy_addr_mult_out <= '0;
      reg_wrt_mul_out   <= 1'b0;
`ifdef MULT_RADIX4_EN
      mcand3            <= '0;
`endif
    end else begin
      state <= state_nxt;
      stall <= (state_nxt != IDLE);
      if (accept) begin
        mcand <= mult_op1;
        mplr  <= mplr_eff;
        acc   <= '0;
        cnt   <= '0;
        idx_q <= mult_done_idx;
        phy_q <= phy_addr_mult;
        wrt_q <= reg_wrt_mul;
`ifdef MULT_RADIX4_EN
        mcand3 <= mult_op1 + (mult_op1 << 1);
`endif
      end else if (state == CALC) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
`ifdef MULT_RADIX4_EN
        mcand  <= mcand << 2;
        mcand3 <= mcand3 << 2;
        mplr   <= mplr >> 2;
`else
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
`endif
        // Outputs only move when a result is actually produced, so a
        // flushed operation leaves the previous result and tags intact.
        if (last_step && !flush) begin
          mult_result       <= acc_nxt;
          mult_done_idx_out <= idx_q;
          phy_addr_mult_out <= phy_q;
          reg_wrt_mul_out   <= wrt_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_ex.sv
module tb_mult_ex;

`ifdef MULT_RADIX4_EN
  localparam int N = 8;
`else
  localparam int N = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mult_en;
  logic        mult_inst_vld;
  logic [15:0] mult_op1;
  logic [15:0] mult_op2;
  logic [15:0] mult_imm;
  logic        mult_imm_vld;
  logic        mult_invtRt;
  logic [5:0]  mult_done_idx;
  logic [5:0]  phy_addr_mult;
  logic        reg_wrt_mul;
  logic        stall;
  logic [15:0] mult_result;
  logic        mult_result_vld;
  logic [5:0]  mult_done_idx_out;
  logic [5:0]  phy_addr_mult_out;
  logic        reg_wrt_mul_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_ex #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mult_en(mult_en), .mult_inst_vld(mult_inst_vld),
    .mult_op1(mult_op1), .mult_op2(mult_op2), .mult_imm(mult_imm),
    .mult_imm_vld(mult_imm_vld), .mult_invtRt(mult_invtRt),
    .mult_done_idx(mult_done_idx), .phy_addr_mult(phy_addr_mult),
    .reg_wrt_mul(reg_wrt_mul),
    .stall(stall), .mult_result(mult_result), .mult_result_vld(mult_result_vld),
    .mult_done_idx_out(mult_done_idx_out), .phy_addr_mult_out(phy_addr_mult_out),
    .reg_wrt_mul_out(reg_wrt_mul_out)
  );

  // Reference: select, optionally invert, multiply, keep the low 16 bits.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] op2,
                                          input logic [15:0] imm, input logic imm_vld,
                                          input logic inv);
    logic [15:0] m;
    logic [31:0] p;
    m = imm_vld ? imm : op2;
    if (inv) m = ~m;
    p = {16'd0, a} * {16'd0, m};
    return p[15:0];
  endfunction

  task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                          input logic imm_vld, input logic inv, input logic [5:0] idx,
                          input logic [5:0] phy, input logic wrt);
    mult_en = 1'b1; mult_inst_vld = 1'b1;
    mult_op1 = a; mult_op2 = b; mult_imm = imm;
    mult_imm_vld = imm_vld; mult_invtRt = inv;
    mult_done_idx = idx; phy_addr_mult = phy; reg_wrt_mul = wrt;
  endtask

  task automatic clear_op();
    mult_en = 1'b0; mult_inst_vld = 1'b0;
    mult_op1 = $urandom; mult_op2 = $urandom; mult_imm = $urandom;
    mult_imm_vld = 1'b0; mult_invtRt = 1'b0;
    mult_done_idx = 6'd0; phy_addr_mult = 6'd0; reg_wrt_mul = 1'b0;
  endtask

  // Presents an operation for one cycle (cycle 0); returns just after the
  // edge that ends cycle 0.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                       input logic imm_vld, input logic inv, input logic [5:0] idx,
                       input logic [5:0] phy, input logic wrt);
    @(posedge clk); #1;
    drive_op(a, b, imm, imm_vld, inv, idx, phy, wrt);
    @(posedge clk); #1;
    clear_op();
  endtask

  // Watches cycles 1..max_cyc (relative to the accept) and reports what it saw.
  task automatic observe(input int max_cyc, output int vld_cyc, output int vld_cnt,
                         output int st_first, output int st_last, output int st_cnt,
                         output logic [15:0] res, output logic [5:0] idx,
                         output logic [5:0] phy, output logic wrt);
    vld_cyc = -1; vld_cnt = 0; st_first = -1; st_last = -1; st_cnt = 0;
    res = 'x; idx = 'x; phy = 'x; wrt = 1'bx;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (stall === 1'b1) begin
        if (st_first < 0) st_first = c;
        st_last = c;
        st_cnt++;
      end
      if (mult_result_vld !== 1'b0) begin
        vld_cnt++;
        if (vld_cyc < 0) begin
          vld_cyc = c; res = mult_result; idx = mult_done_idx_out;
          phy = phy_addr_mult_out; wrt = reg_wrt_mul_out;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (mult_result_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", mult_result_vld); end
    checks++; if (mult_result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", mult_result); end
    checks++; if (mult_done_idx_out !== 6'h0) begin errors++; $display("FAIL reset_idx got %h want 00", mult_done_idx_out); end
    checks++; if (phy_addr_mult_out !== 6'h0) begin errors++; $display("FAIL reset_phy got %h want 00", phy_addr_mult_out); end
    checks++; if (reg_wrt_mul_out !== 1'b0) begin errors++; $display("FAIL reset_wrt got %b want 0", reg_wrt_mul_out); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int vc, vn, sf, sl, sn; logic [15:0] r; logic [5:0] ix, ph; logic w;
    issue(16'd3, 16'd5, 16'h0, 1'b0, 1'b0, 6'h07, 6'h21, 1'b1);
    observe(N + 4, vc, vn, sf, sl, sn, r, ix, ph, w);
    checks++; if (vc != N + 1) begin errors++; $display("FAIL basic_vld_cycle got %0d want %0d", vc, N + 1); end
    checks++; if (vn != 1) begin errors++; $display("FAIL basic_vld_count got %0d want 1", vn); end
    checks++; if (sf != 1 || sl != N + 1 || sn != N + 1) begin
      errors++; $display("FAIL basic_stall got cycles %0d..%0d (%0d) want 1..%0d", sf, sl, sn, N + 1); end
    checks++; if (r !== 16'h000F) begin errors++; $display("FAIL basic_result got %h want 000f", r); end
    checks++; if (ix !== 6'h07) begin errors++; $display("FAIL basic_idx got %h want 07", ix); end
    checks++; if (ph !== 6'h21) begin errors++; $display("FAIL basic_phy got %h want 21", ph); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL basic_wrt got %b want 1", w); end
  endtask

  task automatic test_imm_select();
    int vc, vn, sf, sl, sn; logic [15:0] r; logic [5:0] ix, ph; logic w;
    issue(16'h1234, 16'hFFFF, 16'h0010, 1'b1, 1'b0, 6'h11, 6'h02, 1'b0);
    observe(N + 2, vc, vn, sf, sl, sn, r, ix, ph, w);
    checks++; if (vc != N + 1 || r !== 16'h2340) begin
      errors++; $display("FAIL imm_result got %h at cycle %0d want 2340 at %0d", r, vc, N + 1); end
    checks++; if (w !== 1'b0 || ix !== 6'h11) begin
      errors++; $display("FAIL imm_tags got wrt=%b idx=%h want wrt=0 idx=11", w, ix); end
  endtask

  task automatic test_invert();
    int vc, vn, sf, sl, sn; logic [15:0] r; logic [5:0] ix, ph; logic w;
    issue(16'd3, 16'h0001, 16'h5555, 1'b0, 1'b1, 6'h3F, 6'h3E, 1'b1);
    observe(N + 2, vc, vn, sf, sl, sn, r, ix, ph, w);
    checks++; if (vc != N + 1 || r !== 16'hFFFA) begin
      errors++; $display("FAIL invert_result got %h at cycle %0d want fffa at %0d", r, vc, N + 1); end
    checks++; if (ph !== 6'h3E) begin errors++; $display("FAIL invert_phy got %h want 3e", ph); end
  endtask

  task automatic test_flush_mid();
    int vc, vn, sf, sl, sn; logic [15:0] r; logic [5:0] ix, ph; logic w;
    int early_vld = 0;
    issue(16'h0055, 16'h0033, 16'h0, 1'b0, 1'b0, 6'h01, 6'h01, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (mult_result_vld !== 1'b0) early_vld++;
      @(posedge clk); #1;
    end
    flush = 1'b1;                    // cycle 5
    @(negedge clk);
    if (mult_result_vld !== 1'b0) early_vld++;
    @(posedge clk); #1;
    flush = 1'b0;                    // cycle 6
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
    checks++; if (early_vld != 0 || mult_result_vld !== 1'b0) begin
      errors++; $display("FAIL flush_early_vld got %0d strobes want 0", early_vld); end
    drive_op(16'h0101, 16'h0007, 16'h0, 1'b0, 1'b0, 6'h2A, 6'h15, 1'b1);
    @(posedge clk); #1;
    clear_op();
    observe(N + 4, vc, vn, sf, sl, sn, r, ix, ph, w);
    checks++; if (vn != 1 || vc != N + 1) begin
      errors++; $display("FAIL flush_new_vld got %0d strobes first at %0d want 1 at %0d", vn, vc, N + 1); end
    checks++; if (r !== 16'h0707 || ix !== 6'h2A) begin
      errors++; $display("FAIL flush_new_result got %h idx %h want 0707 idx 2a", r, ix); end
  endtask

  task automatic test_flush_idle();
    int vc, vn, sf, sl, sn; logic [15:0] r; logic [5:0] ix, ph; logic w;
    @(posedge clk); #1;
    drive_op(16'h0003, 16'h0003, 16'h0, 1'b0, 1'b0, 6'h05, 6'h05, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    clear_op();
    observe(N + 4, vc, vn, sf, sl, sn, r, ix, ph, w);
    checks++; if (vn != 0 || sn != 0) begin
      errors++; $display("FAIL flush_idle got %0d strobes %0d stall cycles want 0 0", vn, sn); end
  endtask

  task automatic test_back_to_back();
    int a_cyc = -1, b_cyc = -1, b_acc = -1, nv = 0;
    logic [15:0] a_res, b_res;
    logic [5:0] b_idx;
    @(posedge clk); #1;
    drive_op(16'h00FF, 16'h0101, 16'h0, 1'b0, 1'b0, 6'h0A, 6'h0A, 1'b1);
    @(posedge clk); #1;
    drive_op(16'h8000, 16'h0002, 16'h0, 1'b0, 1'b0, 6'h0B, 6'h0B, 1'b1);
    for (int c = 1; c <= 2 * N + 6; c++) begin
      @(negedge clk);
      if (mult_result_vld === 1'b1) begin
        nv++;
        if (a_cyc < 0) begin a_cyc = c; a_res = mult_result; end
        else if (b_cyc < 0) begin b_cyc = c; b_res = mult_result; b_idx = mult_done_idx_out; end
      end
      if (b_acc < 0 && stall === 1'b0) begin
        b_acc = c;
        @(posedge clk); #1;
        clear_op();
      end
    end
    checks++; if (a_cyc != N + 1 || a_res !== 16'hFFFF) begin
      errors++; $display("FAIL b2b_a got %h at %0d want ffff at %0d", a_res, a_cyc, N + 1); end
    checks++; if (b_acc != N + 2) begin errors++; $display("FAIL b2b_accept got %0d want %0d", b_acc, N + 2); end
    checks++; if (b_cyc != 2 * N + 3 || b_res !== 16'h0000 || b_idx !== 6'h0B) begin
      errors++; $display("FAIL b2b_b got %h idx %h at %0d want 0000 idx 0b at %0d", b_res, b_idx, b_cyc, 2 * N + 3); end
    checks++; if (nv != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", nv); end
  endtask

  task automatic test_reset_mid();
    int vc, vn, sf, sl, sn; logic [15:0] r; logic [5:0] ix, ph; logic w;
    issue(16'h1111, 16'h0003, 16'h0, 1'b0, 1'b0, 6'h33, 6'h2C, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;                      // cycle 8
    @(posedge clk); #1;
    rst = 1'b0;                      // cycle 9
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mult_result_vld !== 1'b0 || mult_result !== 16'h0 ||
                  mult_done_idx_out !== 6'h0 || phy_addr_mult_out !== 6'h0 || reg_wrt_mul_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got stall=%b vld=%b res=%h idx=%h phy=%h wrt=%b want all 0",
                         stall, mult_result_vld, mult_result, mult_done_idx_out, phy_addr_mult_out, reg_wrt_mul_out); end
    observe(N + 4, vc, vn, sf, sl, sn, r, ix, ph, w);
    checks++; if (vn != 0 || sn != 0) begin
      errors++; $display("FAIL rstmid_after got %0d strobes %0d stall cycles want 0 0", vn, sn); end
  endtask

  task automatic test_random();
    int vc, vn, sf, sl, sn; logic [15:0] r; logic [5:0] ix, ph; logic w;
    logic [15:0] a, b, im, exp_r; logic iv, inv, wr; logic [5:0] di, pa;
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom); b = 16'($urandom); im = 16'($urandom);
      iv = 1'($urandom); inv = 1'($urandom); wr = 1'($urandom);
      di = 6'($urandom); pa = 6'($urandom);
      exp_r = ref_mul(a, b, im, iv, inv);
      issue(a, b, im, iv, inv, di, pa, wr);
      observe(N + 2, vc, vn, sf, sl, sn, r, ix, ph, w);
      checks++; if (vc != N + 1 || vn != 1 || r !== exp_r) begin
        errors++; $display("FAIL rand_result[%0d] got %h at %0d (%0d strobes) want %h at %0d",
                           k, r, vc, vn, exp_r, N + 1); end
      checks++; if (ix !== di || ph !== pa || w !== wr) begin
        errors++; $display("FAIL rand_tags[%0d] got %h/%h/%b want %h/%h/%b", k, ix, ph, w, di, pa, wr); end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    clear_op();
    test_reset();
    test_basic();
    test_imm_select();
    test_invert();
    test_flush_mid();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
